lp805x_freqsched: RTL and testbench
===================================

LP805X_FREQSCHED -- requirements
Module: lp805x_freqsched

Interface
REQ-001 NUM_SCALES, 8, number of frequency-select entries (legal 2..16).
REQ-002 BASE_SCALE, 16'd1600, threshold of index 0; index k threshold = BASE_SCALE >> k.
REQ-003 IDX_W, 4, width of index fields (>= clog2(NUM_SCALES)).
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 wr  in  1  SFR write strobe.
REQ-008 wr_bit  in  1  bit-write qualifier; byte writes only when 0.
REQ-009 rd  in  1  SFR read strobe (unused for decode, kept for bus compatibility).
REQ-010 rd_bit  in  1  bit-read qualifier (unused).
REQ-011 wr_addr  in  8  SFR write address.
REQ-012 rd_addr  in  8  SFR read address.
REQ-013 data_in  in  8  SFR write data.
REQ-014 bit_in  in  1  bit write data (unused).
REQ-015 data_out  out(tri)  8  SFR read data, high-Z when not addressed.
REQ-016 bit_out  out(tri)  1  always high-Z.
REQ-017 freq_sel  out  IDX_W  current selected index.
REQ-018 busy  out  1  search in progress.
REQ-019 irq  out  1  completion interrupt (see Configuration).

Function
REQ-020 SFRs: SCHEDH 8'he9 = {start, enable, ie, rsvd, factor[15:12]}; SCHEDL 8'hea = factor[11:4]; SCHEDS 8'heb (read-only) = {busy, done, 2'b0, index[3:0]}; factor[3:0] = 0.
REQ-021 start is self-clearing: reads 1 for exactly one cycle after the write, then 0.
REQ-022 FSM states IDLE, SEARCH, DONE; IDLE->SEARCH on start=1 with enable=1 in the written value; start with enable=0 is ignored.
REQ-023 SEARCH begins at k = NUM_SCALES-1, threshold BASE_SCALE >> k; each cycle compares factor <= threshold (16-bit unsigned).
REQ-024 On hit, or when k = 0, index <= k and state -> DONE; otherwise k decrements and the threshold doubles.
REQ-025 Latency: result visible at cycle (NUM_SCALES-k_hit) after the start-write cycle; worst case NUM_SCALES cycles.
REQ-026 DONE lasts one cycle: done flag <= 1, freq_sel <= index, then -> IDLE.
REQ-027 done clears on a SCHEDS read (cycle after rd_addr = 8'heb) or on a new accepted start; set wins over clear.
REQ-028 While busy: SCHEDL writes and start are ignored; a SCHEDH write with enable=0 aborts to IDLE, index and freq_sel unchanged, done not set.
REQ-029 Read data is registered: data_out is valid one cycle after rd_addr matches, high-Z otherwise.
REQ-030 busy = (state == SEARCH).

Reset
REQ-031 rst low: SCHEDH = SCHEDL = 8'h00, state IDLE, index = freq_sel = 0, done = 0, busy = 0, irq = 0, read register 0 and undriven.
REQ-032 Reset mid-search aborts immediately; no partial result survives.

Configuration
REQ-033 LP805X_SCHED_IRQ_EN defined: irq is a level output = done & ie, cleared when done clears.
REQ-034 LP805X_SCHED_IRQ_EN undefined: irq tied 0; ie bit writable, reads back, has no effect.

Structure
REQ-035 Shared package/include holds SFR addresses (SCHEDH/SCHEDL/SCHEDS), SCHEDH bit positions and FSM state encodings.
REQ-036 Sub-module lp805x_sched_search holds FSM, k counter, threshold shifter and comparator; the top holds SFR decode and readback.

Verification
REQ-037 SCHEDL=8'h00, SCHEDH=8'hC0 (factor 0) -> index 7 one cycle after the start write; busy high one cycle.
REQ-038 SCHEDL=8'h01 (factor 16), SCHEDH=8'hC0 -> index 6 after 2 cycles; SCHEDS reads 8'h46 then done clears.
REQ-039 SCHEDL=8'hFF, SCHEDH=8'hCF (factor 65520) -> index 0 after 8 cycles; busy high 8 cycles.
REQ-040 During search write SCHEDH=8'h00 -> busy drops next cycle, freq_sel keeps prior value, done stays 0.
REQ-041 With LP805X_SCHED_IRQ_EN, SCHEDH=8'hE0 -> irq rises with done, falls after SCHEDS read; without macro irq stays 0.
REQ-042 Assert rst mid-search -> all outputs zero asynchronously; SCHEDS reads 8'h00 after release.

Source files
------------

// File: rtl/lp805x_freqsched_pkg.sv
// Shared definitions for the frequency scheduler: SFR map, SCHEDH bit
// positions and search FSM state encodings.
package lp805x_freqsched_pkg;

  localparam logic [7:0] SCHEDH_ADDR = 8'he9;
  localparam logic [7:0] SCHEDL_ADDR = 8'hea;
  localparam logic [7:0] SCHEDS_ADDR = 8'heb;

  localparam int START_BIT = 7;
  localparam int EN_BIT    = 6;
  localparam int IE_BIT    = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/lp805x_sched_search.sv
// Search engine: walks k from NUM_SCALES-1 down to 0 and stops at the first
// threshold (BASE_SCALE >> k) that the factor does not exceed.
import lp805x_freqsched_pkg::*;

module lp805x_sched_search #(
  parameter int          NUM_SCALES = 8,
  parameter logic [15:0] BASE_SCALE = 16'd1600,
  parameter int          IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      factor,
  output logic             busy,
  output logic             idle,
  output logic             fin,
  output logic [IDX_W-1:0] index,
  output logic [IDX_W-1:0] freq_sel
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] k_q;
  logic [15:0]      thr;
  logic             hit, last, stop;

  // Threshold is derived from k directly so non-power-of-two bases stay exact.
  assign thr  = BASE_SCALE >> k_q;
  assign hit  = (factor <= thr);
  assign last = (k_q == '0);
  assign stop = hit | last;

  assign busy = (state_q == ST_SEARCH);
  assign idle = (state_q == ST_IDLE);
  assign fin  = (state_q == ST_DONE);

  // Next-state logic; abort has priority over a result in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SEARCH;
      ST_SEARCH: begin
        if (abort)     state_d = ST_IDLE;
        else if (stop) state_d = ST_DONE;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // k counter, captured index and published frequency select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q      <= '0;
      index    <= '0;
      freq_sel <= '0;
    end else begin
      if (idle && start)
        k_q <= IDX_W'(NUM_SCALES - 1);
      else if (busy && !abort && !stop)
        k_q <= k_q - 1'b1;
      if (busy && !abort && stop)
        index <= k_q;
      if (fin)
        freq_sel <= index;
    end
  end

endmodule

// File: rtl/lp805x_freqsched.sv
// Frequency scheduler SFR block: SCHEDH/SCHEDL/SCHEDS decode, registered
// tristate readback and done/irq flag around the search engine.
// Optional feature macro: LP805X_SCHED_IRQ_EN (irq = done & ie when defined).
import lp805x_freqsched_pkg::*;

module lp805x_freqsched #(
  parameter int          NUM_SCALES = 8,
  parameter logic [15:0] BASE_SCALE = 16'd1600,
  parameter int          IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             wr_bit,
  input  logic             rd,
  input  logic             rd_bit,
  input  logic [7:0]       wr_addr,
  input  logic [7:0]       rd_addr,
  input  logic [7:0]       data_in,
  input  logic             bit_in,
  output logic [7:0]       data_out,
  output logic             bit_out,
  output logic [IDX_W-1:0] freq_sel,
  output logic             busy,
  output logic             irq
);

  logic [7:0]       schedh_q, schedl_q, rdata_q;
  logic             rd_en_q, done_q;
  logic             wr_h, wr_l, start_req, start_acc, abort;
  logic             idle, fin;
  logic [IDX_W-1:0] index;
  logic [15:0]      factor;
  logic [7:0]       scheds;
  logic             rd_hit;
  logic             unused_ok;

  assign unused_ok = ^{rd, rd_bit, bit_in};

  assign wr_h      = wr && !wr_bit && (wr_addr == SCHEDH_ADDR);
  assign wr_l      = wr && !wr_bit && (wr_addr == SCHEDL_ADDR);
  assign start_req = wr_h && data_in[START_BIT] && data_in[EN_BIT];
  assign start_acc = start_req && idle;
  assign abort     = wr_h && !data_in[EN_BIT];
  assign factor    = {schedh_q[3:0], schedl_q, 4'b0000};
  assign scheds    = {busy, done_q, 2'b00, 4'(index)};
  assign rd_hit    = (rd_addr == SCHEDH_ADDR) || (rd_addr == SCHEDL_ADDR) ||
                     (rd_addr == SCHEDS_ADDR);

  lp805x_sched_search #(
    .NUM_SCALES(NUM_SCALES),
    .BASE_SCALE(BASE_SCALE),
    .IDX_W     (IDX_W)
  ) u_search (
    .clk     (clk),
    .rst     (rst),
    .start   (start_req),
    .abort   (abort),
    .factor  (factor),
    .busy    (busy),
    .idle    (idle),
    .fin     (fin),
    .index   (index),
    .freq_sel(freq_sel)
  );

  // Control registers; the factor is frozen while a search runs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      schedh_q <= 8'h00;
      schedl_q <= 8'h00;
    end else begin
      if (wr_h) begin
        if (busy) schedh_q <= {1'b0, data_in[EN_BIT], data_in[IE_BIT], schedh_q[4:0]};
        else      schedh_q <= data_in;
      end else begin
        schedh_q[START_BIT] <= 1'b0;
      end
      if (wr_l && !busy) schedl_q <= data_in;
    end
  end

  // Done flag: set by the DONE state, cleared by a SCHEDS read or new start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      done_q <= 1'b0;
    else if (fin)                                  done_q <= 1'b1;
    else if ((rd_addr == SCHEDS_ADDR) || start_acc) done_q <= 1'b0;
  end

  // Registered readback, presented one cycle after the address matches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en_q <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      rd_en_q <= rd_hit;
      case (rd_addr)
        SCHEDH_ADDR: rdata_q <= schedh_q;
        SCHEDL_ADDR: rdata_q <= schedl_q;
        SCHEDS_ADDR: rdata_q <= scheds;
        default:     rdata_q <= 8'h00;
      endcase
    end
  end

  assign data_out = rd_en_q ? rdata_q : 8'hzz;
  assign bit_out  = 1'bz;

`ifdef LP805X_SCHED_IRQ_EN
  assign irq = done_q & schedh_q[IE_BIT];
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_lp805x_freqsched.sv
// Scoreboard bench for lp805x_freqsched: stimulus pushes expectations into
// queues, monitors pop them on read data, search completion or probe events.
module tb_lp805x_freqsched;

`ifdef LP805X_SCHED_IRQ_EN
  localparam int IRQ_ON = 1;
`else
  localparam int IRQ_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr = 1'b0, wr_bit = 1'b0, rd = 1'b0, rd_bit = 1'b0, bit_in = 1'b0;
  logic [7:0] wr_addr = 8'h00, rd_addr = 8'h00, data_in = 8'h00;
  wire  [7:0] data_out;
  wire        bit_out;
  logic [3:0] freq_sel;
  logic       busy, irq;

  lp805x_freqsched dut (
    .clk(clk), .rst(rst), .wr(wr), .wr_bit(wr_bit), .rd(rd), .rd_bit(rd_bit),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .data_in(data_in), .bit_in(bit_in),
    .data_out(data_out), .bit_out(bit_out), .freq_sel(freq_sel), .busy(busy),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct { string name; int exp; } rd_t;
  typedef struct { string name; int idx; int len; int irq; } cpl_t;
  typedef struct { string name; int sig; int exp; } prb_t;

  rd_t  rd_q[$];
  cpl_t cpl_q[$];
  prb_t prb_q[$];
  event prb_ev;
  int   total = 0;
  int   bad   = 0;

  function automatic void chk(string n, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction

  // Read monitor: data_out is due one cycle after an SFR address was presented.
  logic rd_seen = 1'b0;
  always @(posedge clk) rd_seen = (rd_addr >= 8'he9) && (rd_addr <= 8'heb);
  always @(negedge clk) begin
    if (rd_seen && rst) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        rd_t r;
        r = rd_q.pop_front();
        chk(r.name, int'(data_out), r.exp);
      end
    end
  end

  // Completion monitor: on busy falling, check result one cycle later.
  initial begin
    int   cnt;
    bit   pb;
    cpl_t c;
    cnt = 0;
    pb  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cnt = 0;
        pb  = 1'b0;
      end else begin
        if (busy) cnt++;
        if (pb && !busy) begin
          @(negedge clk);
          if (cpl_q.size() == 0) chk("cpl_unexpected", 1, 0);
          else begin
            c = cpl_q.pop_front();
            chk({c.name, "_freq_sel"}, int'(freq_sel), c.idx);
            chk({c.name, "_busy_len"}, cnt, c.len);
            chk({c.name, "_irq"}, int'(irq), c.irq);
          end
          cnt = 0;
        end
        pb = busy;
      end
    end
  end

  // Probe monitor: immediate checks of busy(0), freq_sel(1), irq(2).
  initial begin
    prb_t p;
    int   act;
    forever begin
      @(prb_ev);
      while (prb_q.size() != 0) begin
        p = prb_q.pop_front();
        case (p.sig)
          0:       act = int'(busy);
          1:       act = int'(freq_sel);
          default: act = int'(irq);
        endcase
        chk(p.name, act, p.exp);
      end
    end
  end

  task automatic probe(input string n, input int sig, input int exp);
    prb_t p;
    p.name = n; p.sig = sig; p.exp = exp;
    prb_q.push_back(p);
    ->prb_ev;
    #0;
  endtask

  // Tasks enter and leave at a falling edge.
  task automatic sfr_wr(input logic [7:0] a, input logic [7:0] d);
    wr = 1'b1; wr_addr = a; data_in = d;
    @(negedge clk);
    wr = 1'b0; wr_addr = 8'h00; data_in = 8'h00;
  endtask

  task automatic sfr_rd(input logic [7:0] a, input int exp, input string n);
    rd_t r;
    r.name = n; r.exp = exp;
    rd_q.push_back(r);
    rd = 1'b1; rd_addr = a;
    @(negedge clk);
    rd = 1'b0; rd_addr = 8'h00;
  endtask

  task automatic expect_cpl(input string n, input int idx, input int len, input int ie);
    cpl_t c;
    c.name = n; c.idx = idx; c.len = len; c.irq = ie;
    cpl_q.push_back(c);
  endtask

  task automatic wait_idle(input string n);
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    if (busy) chk({n, "_timeout"}, 1, 0);
    repeat (3) @(negedge clk);
  endtask

  // Run one search: factor from {hi[3:0], lo}, then check and clear SCHEDS.
  task automatic search(input string n, input logic [7:0] lo, input logic [7:0] hi,
                        input int idx, input int len, input int ie);
    sfr_wr(8'hea, lo);
    expect_cpl(n, idx, len, ie);
    sfr_wr(8'he9, hi);
    wait_idle(n);
    sfr_rd(8'heb, 8'h40 | idx, {n, "_scheds_done"});
    sfr_rd(8'heb, idx, {n, "_scheds_clr"});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    probe("rst_busy", 0, 0);
    probe("rst_freq_sel", 1, 0);
    probe("rst_irq", 2, 0);
    rst = 1'b1;
    @(negedge clk);
    sfr_rd(8'he9, 8'h00, "rst_schedh");
    sfr_rd(8'hea, 8'h00, "rst_schedl");
    sfr_rd(8'heb, 8'h00, "rst_scheds");

    // Factor 0: hit at k=7 in one cycle; start bit self-clears.
    sfr_wr(8'hea, 8'h00);
    expect_cpl("f0", 7, 1, 0);
    sfr_wr(8'he9, 8'hC0);
    sfr_rd(8'he9, 8'hC0, "schedh_start_set");
    sfr_rd(8'he9, 8'h40, "schedh_start_clr");
    wait_idle("f0");
    sfr_rd(8'heb, 8'h47, "f0_scheds_done");
    sfr_rd(8'heb, 8'h07, "f0_scheds_clr");

    // Factor 16: index 6 in two cycles; SCHEDL write while busy is ignored.
    sfr_wr(8'hea, 8'h01);
    expect_cpl("f16", 6, 2, 0);
    sfr_wr(8'he9, 8'hC0);
    sfr_wr(8'hea, 8'hFF);
    wait_idle("f16");
    sfr_rd(8'hea, 8'h01, "f16_schedl_kept");
    sfr_rd(8'heb, 8'h46, "f16_scheds_done");
    sfr_rd(8'heb, 8'h06, "f16_scheds_clr");

    search("f160", 8'h0A, 8'hC0, 3, 5, 0);   // 160 <= 200 at k=3
    search("f400", 8'h19, 8'hC0, 2, 6, 0);   // exactly equal to threshold 400
    search("f416", 8'h1A, 8'hC0, 1, 7, 0);   // one step above 400 -> k=1
    search("fmax", 8'hFF, 8'hCF, 0, 8, 0);   // 65520 bottoms out at k=0

    // Interrupt enabled: irq follows done until SCHEDS read.
    sfr_wr(8'hea, 8'h01);
    expect_cpl("irq", 6, 2, IRQ_ON);
    sfr_wr(8'he9, 8'hE0);
    wait_idle("irq");
    probe("irq_held", 2, IRQ_ON);
    sfr_rd(8'heb, 8'h46, "irq_scheds_done");
    probe("irq_cleared", 2, 0);

    // Abort mid-search: freq_sel keeps 6, done never set.
    sfr_wr(8'hea, 8'hFF);
    expect_cpl("abort", 6, 1, 0);
    sfr_wr(8'he9, 8'hCF);
    sfr_wr(8'he9, 8'h00);
    wait_idle("abort");
    sfr_rd(8'heb, 8'h06, "abort_scheds");

    // Asynchronous reset in the middle of a long search.
    sfr_wr(8'hea, 8'hFF);
    sfr_wr(8'he9, 8'hCF);
    repeat (2) @(negedge clk);
    probe("pre_rst_busy", 0, 1);
    #2 rst = 1'b0;
    #1;
    probe("arst_busy", 0, 0);
    probe("arst_freq_sel", 1, 0);
    probe("arst_irq", 2, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sfr_rd(8'heb, 8'h00, "post_rst_scheds");
    sfr_rd(8'he9, 8'h00, "post_rst_schedh");
    sfr_rd(8'hea, 8'h00, "post_rst_schedl");
    repeat (3) @(negedge clk);

    chk("rd_q_drained", rd_q.size(), 0);
    chk("cpl_q_drained", cpl_q.size(), 0);
    chk("prb_q_drained", prb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
